// File: rtl/multicycle_controller_if.sv
// Control bundle between the RV32I multicycle datapath and its controller.
// The controller drives the selects and enables; the datapath returns the instruction fields and the zero flag.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7_5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               instr_done, illegal, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core: one shared ALU and one unified memory,
// sequenced over 2 to 5 cycles per instruction.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       ctrl
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_e     state_q, state_d, cur_state;
    logic [1:0] alu_op;
    logic       pc_update, branch;
    logic       adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        // While reset is held the outputs present FETCH, whatever the register holds.
        cur_state  = reset ? S_FETCH : state_q;
        state_d    = S_FETCH;
        alu_op     = 2'b00;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;

        case (cur_state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (ctrl.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXECUTER;
                    OP_IMM:            state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (ctrl.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase

        // An abandoned instruction must not commit anything in the reset cycle.
        if (reset) begin
            pc_update  = 1'b0;
            branch     = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (ctrl.funct3)
                    3'b000:  alu_control = (ctrl.opcode[5] & ctrl.funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (ctrl.opcode)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    assign ctrl.pc_write    = pc_update | (branch & ctrl.zero);
    assign ctrl.adr_src     = adr_src;
    assign ctrl.mem_write   = mem_write;
    assign ctrl.ir_write    = ir_write;
    assign ctrl.reg_write   = reg_write;
    assign ctrl.result_src  = result_src;
    assign ctrl.alu_src_a   = alu_src_a;
    assign ctrl.alu_src_b   = alu_src_b;
    assign ctrl.imm_src     = imm_src;
    assign ctrl.alu_control = alu_control;
    assign ctrl.instr_done  = instr_done;
    assign ctrl.illegal     = illegal;
    assign ctrl.state       = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed instructions from the test plan, then random instruction streams,
// each cycle compared against a per-instruction step model.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
    endfunction

    // Observed outputs packed as {pcw,adr,mw,irw,rw,res,srca,srcb,imm,alu,done,ill,state}.
    function automatic logic [31:0] observe();
        return {10'd0, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_control,
                bus.instr_done, bus.illegal, bus.state};
    endfunction

    // ALU operation an R/I execute step needs, straight from the instruction semantics.
    function automatic logic [2:0] exec_alu(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        case (f3)
            3'b000:  return (op == OP_R && f75) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] model(input int s, input logic [6:0] op, input logic [2:0] f3,
                                          input logic f75, input logic z, input logic rst);
        logic pcw, adr, mw, irw, rw, done, ill;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu;
        int st;
        st = rst ? 0 : s;
        {pcw, adr, mw, irw, rw, done, ill} = '0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        imm = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
        case (st)
            0:  begin irw = 1; pcw = 1; sb = 2'b10; res = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(op); done = !is_legal(op); end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1;
            4:  begin res = 2'b01; rw = 1; done = 1; end
            5:  begin adr = 1; mw = 1; done = 1; end
            6:  begin sa = 2'b10; alu = exec_alu(op, f3, f75); end
            7:  begin sa = 2'b10; sb = 2'b01; alu = exec_alu(op, f3, f75); end
            8:  begin rw = 1; done = 1; end
            9:  begin sa = 2'b10; alu = 3'b001; pcw = z; done = 1; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (rst) {pcw, mw, irw, rw, done, ill} = '0;
        return {10'd0, pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, done, ill, st[3:0]};
    endfunction

    // zmode: 0/1 force zero, 2 random per cycle. abort_at: cycle index at which reset is raised (-1 none).
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input int zmode, input int abort_at);
        int seq[$];
        logic z, rst;
        case (op)
            OP_LW:   seq = '{0, 1, 2, 3, 4};
            OP_SW:   seq = '{0, 1, 2, 5};
            OP_R:    seq = '{0, 1, 6, 8};
            OP_I:    seq = '{0, 1, 7, 8};
            OP_JAL:  seq = '{0, 1, 10, 8};
            OP_BEQ:  seq = '{0, 1, 9};
            default: seq = '{0, 1};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            rst          = (i == abort_at);
            z            = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            reset        = rst;
            bus.opcode   = op;
            bus.funct3   = f3;
            bus.funct7_5 = f75;
            bus.zero     = z;
            #1;
            check($sformatf("%s c%0d", name, i), observe(), model(seq[i], op, f3, f75, z, rst));
            if (rst) break;
        end
    endtask

    initial begin
        logic [6:0] op;
        int         pick;
        reset        = 1'b1;
        bus.opcode   = 7'd0;
        bus.funct3   = 3'd0;
        bus.funct7_5 = 1'b0;
        bus.zero     = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset c%0d", i), observe(), model(0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1));
        end

        run_instr("lw",       OP_LW,   3'b010, 1'b0, 2, -1);
        run_instr("sw",       OP_SW,   3'b010, 1'b0, 2, -1);
        run_instr("sub",      OP_R,    3'b000, 1'b1, 2, -1);
        run_instr("addi_f75", OP_I,    3'b000, 1'b1, 2, -1);
        run_instr("beq_z1",   OP_BEQ,  3'b000, 1'b0, 1, -1);
        run_instr("beq_z0",   OP_BEQ,  3'b000, 1'b0, 0, -1);
        run_instr("jal",      OP_JAL,  3'b000, 1'b0, 2, -1);
        run_instr("illegal",  7'h7F,   3'b000, 1'b0, 2, -1);
        run_instr("sw_abort", OP_SW,   3'b010, 1'b0, 2, 3);
        run_instr("after_rst", OP_R,   3'b111, 1'b0, 2, -1);

        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 6);
            case (pick)
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_I;
                4: op = OP_BEQ;
                5: op = OP_JAL;
                default: begin
                    op = 7'($urandom);
                    while (is_legal(op)) op = 7'($urandom);
                end
            endcase
            run_instr($sformatf("rnd%0d", n), op, 3'($urandom), 1'($urandom), 2,
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        @(negedge clk);
        reset = 1'b0;
        bus.opcode = OP_R;
        #1;
        check("final fetch", observe(), model(0, OP_R, bus.funct3, bus.funct7_5, bus.zero, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that moves the RV32I core from single-cycle to multicycle operation, sharing one ALU and one unified instruction/data memory across the steps of each instruction.
- Consumes opcode/funct fields and the ALU zero flag from the datapath. Drives all mux selects, write enables and the ALU operation.
- Moore-style: outputs are a function of the state register, plus the instruction fields for alu_control and imm_src.

Parameters:
- None.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7_5  input  1  instr[30]
- zero  input  1  ALU zero flag
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address select: 0=PC, 1=ALUOut
- mem_write  output  1  memory write enable
- ir_write  output  1  instruction/oldPC register enable
- reg_write  output  1  register file write enable
- result_src  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  output  2  ALU A select: 00=PC, 01=OldPC, 10=rd1 reg
- alu_src_b  output  2  ALU B select: 00=rd2 reg, 01=ImmExt, 10=constant 4
- imm_src  output  2  immediate type: 00=I, 01=S, 10=B, 11=J
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  output  1  high in the final cycle of each instruction
- illegal  output  1  high in the DECODE cycle when the opcode is unsupported
- state  output  4  current state encoding, for debug and verification

Behaviour:
- Reset and signal timing
  - Reset is synchronous and active-high. The clock is clk and the reset is reset.
  - reset high at a clock edge: state <= FETCH (0).
  - While reset is high, pc_write, ir_write, mem_write, reg_write, instr_done and illegal are forced to 0. All other outputs show FETCH values.
  - Reset asserted mid-instruction abandons it. No write enable fires in that cycle.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11-15 go to FETCH on the next edge with all enables 0.
- Outputs not listed for a state default to 0.
- Per-state outputs and transitions:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1. Next: DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next depends on opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 (R-type) -> EXECUTER
    - 0010011 (I-type ALU) -> EXECUTEI
    - 1100011 (beq) -> BEQ
    - 1101111 (jal) -> JAL
    - anything else -> FETCH, with illegal=1 and instr_done=1. This is a nop; the PC is already advanced.
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_done=1. Next: FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, instr_done=1. Next: FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_done=1. Next: FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1. Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB.
- pc_write = pc_update | (branch & zero). This is combinational on zero during the BEQ state.
- ALU decode (alu_op is internal):
  - alu_op 00 -> add; 01 -> sub.
  - alu_op 10, by funct3:
    - 000 -> sub if (opcode[5] & funct7_5), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - others -> add
- imm_src, decoded from opcode in every state: I for lw and I-type ALU, S for sw, B for beq, J for jal, 00 for all others.
- Cycle counts from FETCH to FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- instr_done pulses exactly once per instruction.

Test Plan:
- reset held high for 2 cycles, then released -> state=0 and all enables 0 during reset. First cycle after release: ir_write=1, pc_write=1, alu_src_b=10, result_src=10.
- lw (opcode 0000011) -> states 0,1,2,3,4. MEMREAD has adr_src=1. MEMWB has result_src=01, reg_write=1, instr_done=1. Total 5 cycles.
- sub R-type (opcode 0110011, funct3 000, funct7_5=1) -> states 0,1,6,8. alu_control=001 in EXECUTER. addi with funct7_5=1 gives alu_control=000.
- beq with zero=1, then again with zero=0 -> pc_write=1 in BEQ for zero=1 and pc_write=0 for zero=0. Both take 3 cycles; alu_control=001.
- jal (1101111) -> states 0,1,10,8. JAL has pc_write=1, alu_src_a=01, alu_src_b=10. ALUWB has reg_write=1. imm_src=11 throughout.
- opcode 1111111 in DECODE -> illegal=1, instr_done=1, next state 0. Separately, reset asserted during MEMWRITE -> mem_write=0 that cycle and state=0 next.
